pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_if.sv | 27 ++
 rtl/pll_lock_supervisor.sv | 114 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signals between the PLL lock supervisor, the rPLL wrapper and the downstream reset domain.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       fault;
  logic [7:0] retry_cnt;

  modport master (
    input  pll_lock,
    output pll_reset,
    output sys_rst,
    output locked,
    output fault,
    output retry_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_reset,
    input  sys_rst,
    input  locked,
    input  fault,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset pin, qualifies lock stability and gates the downstream system reset.
// Re-sequences the PLL on lock timeout or on lock loss while running.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clkin,
  input  logic                    reset,
  pll_lock_supervisor_if.master   bus
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int unsigned CW     = $clog2(MAX_C + 1);
  localparam int unsigned RW     = 8;

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   locked_q, locked_d;
  logic                   fault_q, fault_d;
  logic                   lock_s;
  logic                   resequence;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    resequence = 1'b0;
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.pll_lock};

    case (state_q)
      RST_PLL: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d    = RST_PLL;
          resequence = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d    = RST_PLL;
          resequence = 1'b1;
        end
      end
      default: state_d = RST_PLL;
    endcase

    if (state_d != state_q) cnt_d = '0;

    retry_d = retry_q;
    if (resequence && (retry_q != {RW{1'b1}})) retry_d = retry_q + RW'(1);

    fault_d     = resequence;
    pll_reset_d = (state_d == RST_PLL);
    sys_rst_d   = (state_d != RUN);
    locked_d    = (state_d == RUN);
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      sync_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.locked    = locked_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle vector table plus hand-written corner sequences.
module tb_pll_lock_supervisor;

  logic clkin;
  logic reset;
  int   n_checks;
  int   n_err;

  pll_lock_supervisor_if bus_if ();

  pll_lock_supervisor #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .SYNC_STAGES (2)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    logic       rst;
    logic       lock;
    logic       pr;
    logic       sr;
    logic       lk;
    logic       f;
    logic [7:0] rc;
  } vec_t;

  vec_t vq[$];

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_n(input int n, input logic rst, input logic lock, input logic pr,
                        input logic sr, input logic lk, input logic f, input logic [7:0] rc);
    vec_t v;
    v.rst = rst; v.lock = lock; v.pr = pr; v.sr = sr; v.lk = lk; v.f = f; v.rc = rc;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Waits for a fault pulse; returns the number of edges waited, or -1 on expiry.
  task automatic wait_fault(input int max_edges, output int waited);
    waited = -1;
    for (int i = 1; i <= max_edges; i++) begin
      step();
      if (bus_if.fault === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  initial begin
    int waited;
    n_checks       = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus_if.pll_lock = 1'b0;

    step();
    step();
    chk("rst_pll_reset", 32'(bus_if.pll_reset), 32'd1);
    chk("rst_sys_rst",   32'(bus_if.sys_rst),   32'd1);
    chk("rst_locked",    32'(bus_if.locked),    32'd0);
    chk("rst_fault",     32'(bus_if.fault),     32'd0);
    chk("rst_retry_cnt", 32'(bus_if.retry_cnt), 32'd0);

    // Power-up: 4-cycle PLL reset, lock 2 cycles later, RUN 11 edges after the rise.
    push_n(3,  0, 0, 1, 1, 0, 0, 8'd0);
    push_n(3,  0, 0, 0, 1, 0, 0, 8'd0);
    push_n(10, 0, 1, 0, 1, 0, 0, 8'd0);
    push_n(4,  0, 1, 0, 0, 1, 0, 8'd0);
    // Lock loss in RUN: reaction 3 edges later, then a 4-cycle PLL reset.
    push_n(2,  0, 0, 0, 0, 1, 0, 8'd0);
    push_n(1,  0, 0, 1, 1, 0, 1, 8'd1);
    push_n(3,  0, 0, 1, 1, 0, 0, 8'd1);
    // Timeout: 20 cycles in WAIT_LOCK, fault, retry, 4-cycle PLL reset.
    push_n(20, 0, 0, 0, 1, 0, 0, 8'd1);
    push_n(1,  0, 0, 1, 1, 0, 1, 8'd2);
    push_n(3,  0, 0, 1, 1, 0, 0, 8'd2);
    // Glitch in STABLE: 5 high, 3 low, then 8 fresh highs needed.
    push_n(2,  0, 0, 0, 1, 0, 0, 8'd2);
    push_n(5,  0, 1, 0, 1, 0, 0, 8'd2);
    push_n(3,  0, 0, 0, 1, 0, 0, 8'd2);
    push_n(10, 0, 1, 0, 1, 0, 0, 8'd2);
    push_n(3,  0, 1, 0, 0, 1, 0, 8'd2);

    foreach (vq[i]) begin
      reset           = vq[i].rst;
      bus_if.pll_lock = vq[i].lock;
      step();
      chk($sformatf("vec%0d_pll_reset", i), 32'(bus_if.pll_reset), 32'(vq[i].pr));
      chk($sformatf("vec%0d_sys_rst", i),   32'(bus_if.sys_rst),   32'(vq[i].sr));
      chk($sformatf("vec%0d_locked", i),    32'(bus_if.locked),    32'(vq[i].lk));
      chk($sformatf("vec%0d_fault", i),     32'(bus_if.fault),     32'(vq[i].f));
      chk($sformatf("vec%0d_retry_cnt", i), 32'(bus_if.retry_cnt), 32'(vq[i].rc));
    end

    // Asynchronous reset between edges while in RUN.
    #3;
    reset           = 1'b1;
    bus_if.pll_lock = 1'b0;
    #1;
    chk("async_pll_reset", 32'(bus_if.pll_reset), 32'd1);
    chk("async_sys_rst",   32'(bus_if.sys_rst),   32'd1);
    chk("async_locked",    32'(bus_if.locked),    32'd0);
    chk("async_retry_cnt", 32'(bus_if.retry_cnt), 32'd0);
    step();
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rerun_pll_reset_e%0d", k), 32'(bus_if.pll_reset), (k < 4) ? 32'd1 : 32'd0);
    end

    // Timeout/lock race: lock_s first seen high on the cycle the counter reaches 19.
    for (int k = 1; k <= 17; k++) step();
    bus_if.pll_lock = 1'b1;
    for (int k = 18; k <= 28; k++) begin
      step();
      chk($sformatf("race_fault_e%0d", k),   32'(bus_if.fault),     32'd0);
      chk($sformatf("race_retry_e%0d", k),   32'(bus_if.retry_cnt), 32'd0);
      chk($sformatf("race_pll_reset_e%0d", k), 32'(bus_if.pll_reset), 32'd0);
      chk($sformatf("race_locked_e%0d", k),  32'(bus_if.locked),    (k >= 28) ? 32'd1 : 32'd0);
    end

    // Repeated timeouts saturate retry_cnt at 255.
    reset           = 1'b1;
    bus_if.pll_lock = 1'b0;
    step();
    #2;
    reset = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      wait_fault(40, waited);
      if (waited < 0) begin
        chk($sformatf("sat_fault_seen_%0d", n), 32'd0, 32'd1);
        break;
      end
      chk($sformatf("sat_period_%0d", n), 32'(waited), (n == 1) ? 32'd24 : 32'd23);
      chk($sformatf("sat_retry_%0d", n), 32'(bus_if.retry_cnt), (n > 255) ? 32'd255 : 32'(n));
      step();
      chk($sformatf("sat_fault_width_%0d", n), 32'(bus_if.fault), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
